// File: rtl/ddr_axi_wr_burst.sv
// Collects 256-bit words into AXI4 INCR write bursts on DDR controller port 0.
// Define DDR_WR_BID_CHECK_EN to build the sticky BID mismatch flag.
module ddr_axi_wr_burst #(
   parameter int          BURST_LEN = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_SPAN = 32'h0010_0000
) (
   input  logic         axi_clk,
   input  logic         i_rst,
   input  logic [255:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         i_flush,
   output logic [7:0]   DdrCtrl_AID_0,
   output logic [31:0]  DdrCtrl_AADDR_0,
   output logic [7:0]   DdrCtrl_ALEN_0,
   output logic [2:0]   DdrCtrl_ASIZE_0,
   output logic [1:0]   DdrCtrl_ABURST_0,
   output logic [1:0]   DdrCtrl_ALOCK_0,
   output logic         DdrCtrl_AVALID_0,
   input  logic         DdrCtrl_AREADY_0,
   output logic         DdrCtrl_ATYPE_0,
   output logic [7:0]   DdrCtrl_WID_0,
   output logic [255:0] DdrCtrl_WDATA_0,
   output logic [31:0]  DdrCtrl_WSTRB_0,
   output logic         DdrCtrl_WLAST_0,
   output logic         DdrCtrl_WVALID_0,
   input  logic         DdrCtrl_WREADY_0,
   input  logic [7:0]   DdrCtrl_BID_0,
   input  logic         DdrCtrl_BVALID_0,
   output logic         DdrCtrl_BREADY_0,
   output logic         o_busy,
   output logic [15:0]  o_burst_cnt,
   output logic         o_bid_err
);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [32:0] STRIDE   = 33'(BURST_LEN * 32);
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

   typedef enum logic [1:0] {FILL, ADDR, DATA, RESP} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [CW-1:0]  idx;
   logic [CW-1:0]  nextCount;
   logic [CW-1:0]  nextIdx;
   logic [31:0]    wrPtr;
   logic [32:0]    ptrSum;
   logic           accept;
   logic [255:0]   dataBuf [BURST_LEN];
   logic           aValid;
   logic [31:0]    aAddr;
   logic [7:0]     aLen;
   logic           wValid;
   logic           wLast;
   logic [255:0]   wData;
   logic           bReady;
   logic [15:0]    burstCnt;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // once raised, valid and its payload hold until that edge.
   assign s_ready   = (state == FILL) && (count < CW'(BURST_LEN));
   assign accept    = s_valid && s_ready;
   assign nextCount = count + CW'(accept);
   assign nextIdx   = idx + CW'(1);
   assign ptrSum    = {1'b0, wrPtr} + STRIDE;

   always_ff @(posedge axi_clk) begin
      if (accept) dataBuf[count[AW-1:0]] <= s_data;
   end

   always_ff @(posedge axi_clk) begin
      if (i_rst) begin
         state    <= FILL;
         count    <= '0;
         idx      <= '0;
         wrPtr    <= BASE_ADDR;
         aValid   <= 1'b0;
         aAddr    <= BASE_ADDR;
         aLen     <= '0;
         wValid   <= 1'b0;
         wLast    <= 1'b0;
         wData    <= '0;
         bReady   <= 1'b0;
         burstCnt <= '0;
      end else begin
         unique case (state)
            FILL: begin
               count <= nextCount;
               // The word accepted this cycle counts toward a flush-triggered burst.
               if (nextCount == CW'(BURST_LEN) || (i_flush && nextCount != '0)) begin
                  state  <= ADDR;
                  aValid <= 1'b1;
                  aAddr  <= wrPtr;
                  aLen   <= 8'(nextCount - CW'(1));
               end
            end
            ADDR: begin
               if (DdrCtrl_AREADY_0) begin
                  aValid <= 1'b0;
                  state  <= DATA;
                  idx    <= '0;
                  wValid <= 1'b1;
                  wData  <= dataBuf[0];
                  wLast  <= (count == CW'(1));
               end
            end
            DATA: begin
               if (DdrCtrl_WREADY_0) begin
                  if (wLast) begin
                     wValid <= 1'b0;
                     wLast  <= 1'b0;
                     bReady <= 1'b1;
                     state  <= RESP;
                  end else begin
                     idx   <= nextIdx;
                     wData <= dataBuf[nextIdx[AW-1:0]];
                     wLast <= (nextIdx == count - CW'(1));
                  end
               end
            end
            RESP: begin
               if (DdrCtrl_BVALID_0) begin
                  bReady   <= 1'b0;
                  burstCnt <= burstCnt + 16'd1;
                  count    <= '0;
                  idx      <= '0;
                  state    <= FILL;
                  // Partial bursts still step a whole stride so bursts stay aligned.
                  wrPtr    <= (ptrSum >= END_ADDR) ? BASE_ADDR : ptrSum[31:0];
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef DDR_WR_BID_CHECK_EN
   logic bidErr;
   always_ff @(posedge axi_clk) begin
      if (i_rst) bidErr <= 1'b0;
      else if (state == RESP && DdrCtrl_BVALID_0 && DdrCtrl_BID_0 != 8'h00) bidErr <= 1'b1;
   end
   assign o_bid_err = bidErr;
`else
   logic unusedBid;
   assign unusedBid = ^DdrCtrl_BID_0;
   assign o_bid_err = 1'b0;
`endif

   assign DdrCtrl_AID_0    = 8'h00;
   assign DdrCtrl_AADDR_0  = aAddr;
   assign DdrCtrl_ALEN_0   = aLen;
   assign DdrCtrl_ASIZE_0  = 3'b101;
   assign DdrCtrl_ABURST_0 = 2'b01;
   assign DdrCtrl_ALOCK_0  = 2'b00;
   assign DdrCtrl_AVALID_0 = aValid;
   assign DdrCtrl_ATYPE_0  = 1'b1;
   assign DdrCtrl_WID_0    = 8'h00;
   assign DdrCtrl_WDATA_0  = wData;
   assign DdrCtrl_WSTRB_0  = '1;
   assign DdrCtrl_WLAST_0  = wLast;
   assign DdrCtrl_WVALID_0 = wValid;
   assign DdrCtrl_BREADY_0 = bReady;
   assign o_busy           = (state != FILL);
   assign o_burst_cnt      = burstCnt;
endmodule

// File: tb/tb_ddr_axi_wr_burst.sv
// Bench for ddr_axi_wr_burst: burst table, stall/reset/BID sequences and randomized
// bursts scored against a queue-based model of the expected AXI traffic.
module tb_ddr_axi_wr_burst;
   localparam int          BL   = 4;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] SPAN = 32'h0000_0100;

   logic         axi_clk = 1'b0;
   logic         i_rst;
   logic [255:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic         i_flush;
   logic [7:0]   AID;
   logic [31:0]  AADDR;
   logic [7:0]   ALEN;
   logic [2:0]   ASIZE;
   logic [1:0]   ABURST;
   logic [1:0]   ALOCK;
   logic         AVALID;
   logic         AREADY;
   logic         ATYPE;
   logic [7:0]   WID;
   logic [255:0] WDATA;
   logic [31:0]  WSTRB;
   logic         WLAST;
   logic         WVALID;
   logic         WREADY;
   logic [7:0]   BID;
   logic         BVALID;
   logic         BREADY;
   logic         o_busy;
   logic [15:0]  o_burst_cnt;
   logic         o_bid_err;

   always #5 axi_clk = ~axi_clk;

   ddr_axi_wr_burst #(.BURST_LEN(BL), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN)) dut (
      .axi_clk(axi_clk), .i_rst(i_rst), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .i_flush(i_flush),
      .DdrCtrl_AID_0(AID), .DdrCtrl_AADDR_0(AADDR), .DdrCtrl_ALEN_0(ALEN),
      .DdrCtrl_ASIZE_0(ASIZE), .DdrCtrl_ABURST_0(ABURST), .DdrCtrl_ALOCK_0(ALOCK),
      .DdrCtrl_AVALID_0(AVALID), .DdrCtrl_AREADY_0(AREADY), .DdrCtrl_ATYPE_0(ATYPE),
      .DdrCtrl_WID_0(WID), .DdrCtrl_WDATA_0(WDATA), .DdrCtrl_WSTRB_0(WSTRB),
      .DdrCtrl_WLAST_0(WLAST), .DdrCtrl_WVALID_0(WVALID), .DdrCtrl_WREADY_0(WREADY),
      .DdrCtrl_BID_0(BID), .DdrCtrl_BVALID_0(BVALID), .DdrCtrl_BREADY_0(BREADY),
      .o_busy(o_busy), .o_burst_cnt(o_burst_cnt), .o_bid_err(o_bid_err)
   );

   int total = 0;
   int bad = 0;

   // Scoreboard: expected address beats {addr, len} and data beats {last, data}.
   logic [39:0]  exp_a_q[$];
   logic [256:0] exp_w_q[$];
   logic [255:0] pendWords[$];
   logic [31:0]  modelPtr = BASE;
   int           expBursts = 0;

   int aMode = 0;
   int wMode = 0;
   int wHs = 0;
   int bDelay = 0;
   logic aOut = 1'b0, pendB = 1'b0, prevStall = 1'b0, heldLast = 1'b0;
   logic rstSeen = 1'b0, bHs = 1'b0;
   logic [255:0] heldData;
   logic [39:0]  eA;
   logic [256:0] eW;
   logic [31:0]  lastAddr = '0;
   logic [7:0]   lastLen = '0;

   typedef struct {
      int          n;
      int          fm;
      logic [31:0] addr;
      logic [7:0]  len;
   } vec_t;
   vec_t vecs[7];

   function automatic void check(input string name, input logic [263:0] act, input logic [263:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endfunction

   // A completed burst writes the collected words to the current slot; the slot then
   // steps one full stride around the region.
   function automatic void modelClose();
      int n = pendWords.size();
      exp_a_q.push_back({modelPtr, 8'(n - 1)});
      for (int i = 0; i < n; i++) exp_w_q.push_back({(i == n - 1), pendWords[i]});
      pendWords.delete();
      modelPtr = 32'(longint'(BASE) + ((longint'(modelPtr) - longint'(BASE) + BL * 32) % longint'(SPAN)));
      expBursts++;
   endfunction

   // AXI slave responder and monitor.
   initial begin
      AREADY = 1'b0;
      WREADY = 1'b0;
      BVALID = 1'b0;
      forever begin
         @(negedge axi_clk);
         rstSeen = i_rst;
         bHs = 1'b0;
         if (i_rst) begin
            aOut = 1'b0;
            pendB = 1'b0;
            prevStall = 1'b0;
         end else begin
            if (AVALID && AREADY) begin
               check("aw_pending", exp_a_q.size() != 0, 1);
               if (exp_a_q.size() != 0) begin
                  eA = exp_a_q.pop_front();
                  check("aw_addr", AADDR, eA[39:8]);
                  check("aw_len", ALEN, eA[7:0]);
               end
               lastAddr = AADDR;
               lastLen = ALEN;
               aOut = 1'b1;
            end
            if (WVALID) check("w_after_aw", aOut, 1);
            if (prevStall) check("w_hold", {WVALID, WLAST, WDATA}, {1'b1, heldLast, heldData});
            if (WVALID && WREADY) begin
               wHs++;
               check("w_pending", exp_w_q.size() != 0, 1);
               if (exp_w_q.size() != 0) begin
                  eW = exp_w_q.pop_front();
                  check("w_data", WDATA, eW[255:0]);
                  check("w_last", WLAST, eW[256]);
               end
               if (WLAST) begin
                  pendB = 1'b1;
                  bDelay = $urandom_range(0, 3);
                  aOut = 1'b0;
               end
            end
            prevStall = WVALID && !WREADY;
            heldData = WDATA;
            heldLast = WLAST;
            bHs = BVALID && BREADY;
         end
         @(posedge axi_clk);
         #1;
         AREADY = (aMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (wMode == 0) WREADY = 1'b1;
         else if (wMode == 1) WREADY = ~WREADY;
         else if (wMode == 2) WREADY = 1'($urandom_range(0, 1));
         if (rstSeen || bHs) BVALID = 1'b0;
         else if (pendB) begin
            if (bDelay == 0) begin
               BVALID = 1'b1;
               pendB = 1'b0;
            end else bDelay--;
         end
      end
   end

   task automatic pushWord(input logic [255:0] w, input bit fl);
      int t = 0;
      s_data = w;
      s_valid = 1'b1;
      i_flush = fl;
      @(negedge axi_clk);
      while (!s_ready && t < 200) begin
         @(negedge axi_clk);
         t++;
      end
      check("s_ready_wait", s_ready, 1);
      @(posedge axi_clk);
      #1;
      s_valid = 1'b0;
      i_flush = 1'b0;
   endtask

   task automatic waitIdle(output bit leak);
      int t = 0;
      leak = 1'b0;
      while (o_busy && t < 1000) begin
         @(negedge axi_clk);
         if (o_busy && s_ready) leak = 1'b1;
         t++;
      end
      check("idle_timeout", o_busy, 0);
      @(posedge axi_clk);
      #1;
   endtask

   task automatic runBurst(input int n, input int fm, input bit gaps);
      logic [255:0] w;
      bit leak;
      for (int k = 0; k < n; k++) begin
         w = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge axi_clk);
            #1;
         end
         pendWords.push_back(w);
         pushWord(w, fm == 1 && k == n - 1);
      end
      if (fm == 2) begin
         i_flush = 1'b1;
         @(posedge axi_clk);
         #1;
         i_flush = 1'b0;
      end
      modelClose();
      check("aw_latency", AVALID, 1);
      check("s_ready_busy", s_ready, 0);
      waitIdle(leak);
      check("s_ready_leak", leak, 0);
      check("burst_cnt", o_burst_cnt, 16'(expBursts));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] w;
      int t;
      int h0;
      vecs[0] = '{4, 0, 32'h00, 8'd3};
      vecs[1] = '{4, 0, 32'h80, 8'd3};
      vecs[2] = '{4, 0, 32'h00, 8'd3};
      vecs[3] = '{2, 1, 32'h80, 8'd1};
      vecs[4] = '{1, 2, 32'h00, 8'd0};
      vecs[5] = '{3, 1, 32'h80, 8'd2};
      vecs[6] = '{2, 2, 32'h00, 8'd1};

      i_rst = 1'b1;
      s_valid = 1'b0;
      s_data = '0;
      i_flush = 1'b0;
      BID = 8'h00;
      repeat (3) @(posedge axi_clk);
      #1;
      i_rst = 1'b0;
      check("rst_avalid", AVALID, 0);
      check("rst_wvalid", WVALID, 0);
      check("rst_wlast", WLAST, 0);
      check("rst_bready", BREADY, 0);
      check("rst_busy", o_busy, 0);
      check("rst_bid_err", o_bid_err, 0);
      check("rst_burst_cnt", o_burst_cnt, 0);
      check("rst_aaddr", AADDR, BASE);
      check("rst_alen", ALEN, 0);
      check("rst_s_ready", s_ready, 1);
      check("const_fields", {AID, ASIZE, ABURST, ALOCK, ATYPE, WID, WSTRB},
            {8'h00, 3'b101, 2'b01, 2'b00, 1'b1, 8'h00, 32'hFFFF_FFFF});

      // Flush with an empty buffer must not start a burst.
      i_flush = 1'b1;
      repeat (3) begin
         @(posedge axi_clk);
         #1;
      end
      i_flush = 1'b0;
      check("empty_flush_busy", o_busy, 0);
      check("empty_flush_avalid", AVALID, 0);

      // Reset while in the data phase, after the first beat.
      wMode = 3;
      WREADY = 1'b0;
      for (int k = 0; k < BL; k++) begin
         w = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
         pendWords.push_back(w);
         pushWord(w, 1'b0);
      end
      modelClose();
      t = 0;
      @(negedge axi_clk);
      while (!WVALID && t < 50) begin
         @(negedge axi_clk);
         t++;
      end
      check("rst_test_wvalid_seen", WVALID, 1);
      @(posedge axi_clk);
      #1;
      WREADY = 1'b1;
      @(posedge axi_clk);
      #1;
      WREADY = 1'b0;
      i_rst = 1'b1;
      exp_a_q.delete();
      exp_w_q.delete();
      pendWords.delete();
      modelPtr = BASE;
      expBursts = 0;
      @(posedge axi_clk);
      #1;
      check("midrst_wvalid", WVALID, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_s_ready", s_ready, 1);
      check("midrst_avalid", AVALID, 0);
      check("midrst_bready", BREADY, 0);
      check("midrst_burst_cnt", o_burst_cnt, 0);
      i_rst = 1'b0;
      wMode = 0;

      // Table: full, wrapping and flushed partial bursts.
      for (int i = 0; i < 7; i++) begin
         runBurst(vecs[i].n, vecs[i].fm, 1'b0);
         check($sformatf("vec%0d_aaddr", i), lastAddr, vecs[i].addr);
         check($sformatf("vec%0d_alen", i), lastLen, vecs[i].len);
      end

      // WREADY toggling: data held through stalls, exactly BL beats.
      wMode = 1;
      h0 = wHs;
      runBurst(BL, 0, 1'b0);
      check("toggle_beats", 32'(wHs - h0), BL);
      wMode = 0;

      // Non-zero response ID.
      check("bid_err_clean", o_bid_err, 0);
      BID = 8'h05;
      runBurst(BL, 0, 1'b0);
      BID = 8'h00;
`ifdef DDR_WR_BID_CHECK_EN
      check("bid_err_set", o_bid_err, 1);
      runBurst(2, 1, 1'b0);
      check("bid_err_sticky", o_bid_err, 1);
`else
      check("bid_err_off", o_bid_err, 0);
      runBurst(2, 1, 1'b0);
      check("bid_err_off_after", o_bid_err, 0);
`endif

      // Randomized bursts with random backpressure.
      aMode = 1;
      wMode = 2;
      for (int i = 0; i < 24; i++) begin
         t = $urandom_range(1, BL);
         runBurst(t, (t == BL) ? 0 : $urandom_range(1, 2), 1'b1);
      end
      aMode = 0;
      wMode = 0;

      repeat (4) @(posedge axi_clk);
      #1;
      check("aw_queue_drained", exp_a_q.size(), 0);
      check("w_queue_drained", exp_w_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
